// File: rtl/spike_vote_classifier.sv
// Spike-count voting classifier: runs NUM_TIMESTEPS layer passes per image,
// accumulates the per-neuron output spikes, then scans for the winning class.
module spike_vote_classifier #(
  parameter int unsigned NUM_NEURONS   = 10,
  parameter int unsigned NUM_TIMESTEPS = 16,
  parameter int unsigned COUNT_WIDTH   = $clog2(NUM_TIMESTEPS + 1),
  parameter int unsigned CLASS_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   layer_done_i,
  input  logic [NUM_NEURONS-1:0] spikes_in_i,
  output logic                   layer_start_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] timestep_o,
  output logic                   result_valid_o,
  output logic [CLASS_WIDTH-1:0] class_out_o,
  output logic [COUNT_WIDTH-1:0] max_count_o,
  output logic                   tie_flag_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [COUNT_WIDTH-1:0] LAST_STEP = COUNT_WIDTH'(NUM_TIMESTEPS);
  localparam logic [CLASS_WIDTH-1:0] LAST_IDX  = CLASS_WIDTH'(NUM_NEURONS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [2:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] timestep_q, timestep_d;
  logic                   ld_q, ld_d;
  logic [CLASS_WIDTH-1:0] idx_q, idx_d;
  logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
  logic                   tie_q, tie_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic                   tie_flag_q, tie_flag_d;
  logic                   layer_start_q, layer_start_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] cur_cnt_c;
  logic                   edge_c;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timestep_d = timestep_q;
    ld_d       = layer_done_i;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    tie_d      = tie_q;
    class_d    = class_q;
    max_d      = max_q;
    tie_flag_d = tie_flag_q;
    edge_c     = layer_done_i & ~ld_q;
    cur_cnt_c  = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx_q == CLASS_WIDTH'(i)) cur_cnt_c = cnt_q[i];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_LAUNCH;
          ld_d       = 1'b0;
          timestep_d = '0;
          idx_d      = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          tie_d      = 1'b0;
          class_d    = '0;
          max_d      = '0;
          tie_flag_d = 1'b0;
          for (int i = 0; i < NUM_NEURONS; i++) cnt_d[i] = '0;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (edge_c) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (spikes_in_i[i] && (cnt_q[i] != CNT_MAX)) begin
              cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
          end
          timestep_d = timestep_q + COUNT_WIDTH'(1);
          if (timestep_d == LAST_STEP) begin
            state_d = S_SCAN;
            idx_d   = '0;
          end else begin
            state_d = S_LAUNCH;
            ld_d    = 1'b0;
          end
        end
      end
      S_SCAN: begin
        // Strict greater-than keeps the lowest index on ties.
        if (idx_q == '0) begin
          best_idx_d = '0;
          best_cnt_d = cur_cnt_c;
          tie_d      = 1'b0;
        end else if (cur_cnt_c > best_cnt_q) begin
          best_idx_d = idx_q;
          best_cnt_d = cur_cnt_c;
          tie_d      = 1'b0;
        end else if (cur_cnt_c == best_cnt_q) begin
          tie_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d    = S_DONE;
          class_d    = best_idx_d;
          max_d      = best_cnt_d;
          tie_flag_d = tie_d;
        end else begin
          idx_d = idx_q + CLASS_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    layer_start_d = (state_d == S_LAUNCH);
    busy_d        = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_SCAN);
    valid_d       = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timestep_q    <= '0;
      ld_q          <= 1'b0;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_cnt_q    <= '0;
      tie_q         <= 1'b0;
      class_q       <= '0;
      max_q         <= '0;
      tie_flag_q    <= 1'b0;
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      timestep_q    <= timestep_d;
      ld_q          <= ld_d;
      idx_q         <= idx_d;
      best_idx_q    <= best_idx_d;
      best_cnt_q    <= best_cnt_d;
      tie_q         <= tie_d;
      class_q       <= class_d;
      max_q         <= max_d;
      tie_flag_q    <= tie_flag_d;
      layer_start_q <= layer_start_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign layer_start_o  = layer_start_q;
  assign busy_o         = busy_q;
  assign timestep_o     = timestep_q;
  assign result_valid_o = valid_q;
  assign class_out_o    = class_q;
  assign max_count_o    = max_q;
  assign tie_flag_o     = tie_flag_q;

endmodule
